// File: rtl/mm_port_initiator.sv
// Single-word main-memory initiator: one command at a time, valid/ack memory port, timeout error.
// Optional build macro MM_RETRY_EN adds re-issue with a 1-cycle BACKOFF after each timeout.
module mm_port_initiator #(
   parameter int ADDR_WIDTH     = 10,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
`ifdef MM_RETRY_EN
   ,
   parameter int MAX_RETRIES    = 2
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cc_req_valid,
   output logic                  cc_req_ready,
   input  logic                  cc_req_write,
   input  logic [ADDR_WIDTH-1:0] cc_req_addr,
   input  logic [DATA_WIDTH-1:0] cc_req_wdata,
   output logic                  cc_resp_valid,
   input  logic                  cc_resp_ready,
   output logic [DATA_WIDTH-1:0] cc_resp_rdata,
   output logic                  cc_resp_err,
   output logic                  mm_req,
   output logic                  mm_we,
   output logic [ADDR_WIDTH-1:0] mm_addr,
   output logic [DATA_WIDTH-1:0] mm_wdata,
   input  logic                  mm_ack,
   input  logic [DATA_WIDTH-1:0] mm_rdata
);

   localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

`ifdef MM_RETRY_EN
   localparam int RTY_W = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRIES);
`endif

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_RESP    = 2'd2
`ifdef MM_RETRY_EN
      ,
      S_BACKOFF = 2'd3
`endif
   } state_t;

   state_t                state_q;
   logic                  req_ready_q;
   logic                  resp_valid_q;
   logic [DATA_WIDTH-1:0] resp_rdata_q;
   logic                  resp_err_q;
   logic                  mm_req_q;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [TMO_W-1:0]      tmo_q;
`ifdef MM_RETRY_EN
   logic [RTY_W-1:0]      rty_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         mm_req_q     <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         tmo_q        <= '0;
`ifdef MM_RETRY_EN
         rty_q        <= '0;
`endif
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (cc_req_valid) begin
                  we_q        <= cc_req_write;
                  addr_q      <= cc_req_addr;
                  wdata_q     <= cc_req_wdata;
                  tmo_q       <= '0;
                  req_ready_q <= 1'b0;
                  mm_req_q    <= 1'b1;
                  state_q     <= S_WAIT;
               end
            end
            S_WAIT: begin
               // ack is tested first so an ack on the timeout cycle still completes cleanly
               if (mm_ack) begin
                  resp_rdata_q <= we_q ? '0 : mm_rdata;
                  resp_err_q   <= 1'b0;
                  resp_valid_q <= 1'b1;
                  mm_req_q     <= 1'b0;
                  state_q      <= S_RESP;
               end else if (tmo_q == TMO_LAST) begin
`ifdef MM_RETRY_EN
                  if (rty_q < RTY_MAX) begin
                     rty_q    <= rty_q + 1'b1;
                     tmo_q    <= '0;
                     mm_req_q <= 1'b0;
                     state_q  <= S_BACKOFF;
                  end else begin
                     resp_rdata_q <= '0;
                     resp_err_q   <= 1'b1;
                     resp_valid_q <= 1'b1;
                     mm_req_q     <= 1'b0;
                     state_q      <= S_RESP;
                  end
`else
                  resp_rdata_q <= '0;
                  resp_err_q   <= 1'b1;
                  resp_valid_q <= 1'b1;
                  mm_req_q     <= 1'b0;
                  state_q      <= S_RESP;
`endif
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
`ifdef MM_RETRY_EN
            S_BACKOFF: begin
               mm_req_q <= 1'b1;
               state_q  <= S_WAIT;
            end
`endif
            S_RESP: begin
               if (cc_resp_ready) begin
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  tmo_q        <= '0;
`ifdef MM_RETRY_EN
                  rty_q        <= '0;
`endif
                  state_q      <= S_IDLE;
               end
            end
            default: begin
               resp_valid_q <= 1'b0;
               mm_req_q     <= 1'b0;
               req_ready_q  <= 1'b1;
               state_q      <= S_IDLE;
            end
         endcase
      end
   end

   assign cc_req_ready  = req_ready_q;
   assign cc_resp_valid = resp_valid_q;
   assign cc_resp_rdata = resp_rdata_q;
   assign cc_resp_err   = resp_err_q;
   assign mm_req        = mm_req_q;
   assign mm_we         = we_q;
   assign mm_addr       = addr_q;
   assign mm_wdata      = wdata_q;

endmodule

// File: tb/tb_mm_port_initiator.sv
// Directed bench for mm_port_initiator with a response scoreboard; honours MM_RETRY_EN.
module tb_mm_port_initiator;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          cc_req_valid;
   logic          cc_req_ready;
   logic          cc_req_write;
   logic [AW-1:0] cc_req_addr;
   logic [DW-1:0] cc_req_wdata;
   logic          cc_resp_valid;
   logic          cc_resp_ready;
   logic [DW-1:0] cc_resp_rdata;
   logic          cc_resp_err;
   logic          mm_req;
   logic          mm_we;
   logic [AW-1:0] mm_addr;
   logic [DW-1:0] mm_wdata;
   logic          mm_ack;
   logic [DW-1:0] mm_rdata;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
   } resp_t;

   resp_t       sb_q[$];
   int unsigned errors = 0;
   int unsigned checks = 0;

   mm_port_initiator #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .cc_req_valid  (cc_req_valid),
      .cc_req_ready  (cc_req_ready),
      .cc_req_write  (cc_req_write),
      .cc_req_addr   (cc_req_addr),
      .cc_req_wdata  (cc_req_wdata),
      .cc_resp_valid (cc_resp_valid),
      .cc_resp_ready (cc_resp_ready),
      .cc_resp_rdata (cc_resp_rdata),
      .cc_resp_err   (cc_resp_err),
      .mm_req        (mm_req),
      .mm_we         (mm_we),
      .mm_addr       (mm_addr),
      .mm_wdata      (mm_wdata),
      .mm_ack        (mm_ack),
      .mm_rdata      (mm_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit push, input logic [DW-1:0] exp_rdata, input logic exp_err);
      resp_t r;
      chk("req_ready_before_issue", {63'd0, cc_req_ready}, 64'd1);
      cc_req_valid = 1'b1;
      cc_req_write = w;
      cc_req_addr  = a;
      cc_req_wdata = d;
      tick();
      cc_req_valid = 1'b0;
      cc_req_write = 1'b0;
      cc_req_addr  = '0;
      cc_req_wdata = '0;
      if (push) begin
         r.rdata = exp_rdata;
         r.err   = exp_err;
         sb_q.push_back(r);
      end
   endtask

   // mm_req must be high for n cycles; memory acks in the n-th one
   task automatic ack_after(input int n, input logic [DW-1:0] data);
      for (int i = 1; i <= n; i++) begin
         chk("mm_req_in_wait", {63'd0, mm_req}, 64'd1);
         if (i == n) begin
            mm_ack   = 1'b1;
            mm_rdata = data;
         end
         tick();
         mm_ack   = 1'b0;
         mm_rdata = '0;
      end
      chk("mm_req_drop_after_ack", {63'd0, mm_req}, 64'd0);
      chk("resp_valid_latency", {63'd0, cc_resp_valid}, 64'd1);
   endtask

   task automatic count_req(output int n);
      n = 0;
      while (mm_req && n < 100) begin
         n++;
         tick();
      end
   endtask

   task automatic handshake();
      resp_t r;
      int    c = 0;
      while (!cc_resp_valid && c < 64) begin
         tick();
         c++;
      end
      chk("resp_valid_seen", {63'd0, cc_resp_valid}, 64'd1);
      chk("req_ready_low_in_resp", {63'd0, cc_req_ready}, 64'd0);
      chk("sb_nonempty", {63'd0, (sb_q.size() != 0)}, 64'd1);
      if (sb_q.size() != 0) begin
         r = sb_q.pop_front();
         chk("resp_rdata", {32'd0, cc_resp_rdata}, {32'd0, r.rdata});
         chk("resp_err", {63'd0, cc_resp_err}, {63'd0, r.err});
      end
      cc_resp_ready = 1'b1;
      tick();
      cc_resp_ready = 1'b0;
      chk("resp_valid_clear", {63'd0, cc_resp_valid}, 64'd0);
      chk("req_ready_after_hs", {63'd0, cc_req_ready}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset         = 1'b1;
      cc_req_valid  = 1'b0;
      cc_req_write  = 1'b0;
      cc_req_addr   = '0;
      cc_req_wdata  = '0;
      cc_resp_ready = 1'b0;
      mm_ack        = 1'b0;
      mm_rdata      = '0;
      repeat (2) tick();

      chk("rst_req_ready", {63'd0, cc_req_ready}, 64'd1);
      chk("rst_resp_valid", {63'd0, cc_resp_valid}, 64'd0);
      chk("rst_resp_rdata", {32'd0, cc_resp_rdata}, 64'd0);
      chk("rst_resp_err", {63'd0, cc_resp_err}, 64'd0);
      chk("rst_mm_req", {63'd0, mm_req}, 64'd0);
      chk("rst_mm_fields", {21'd0, mm_we, mm_addr, mm_wdata}, 64'd0);
      reset = 1'b0;
      tick();

      // read, ack after 3 cycles
      issue(1'b0, 10'd5, 32'h0, 1'b1, 32'h5, 1'b0);
      ack_after(3, 32'h5);
      handshake();

      // back-to-back write at top address, ack after 1 cycle
      issue(1'b1, 10'h3FF, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
      chk("wr_mm_we", {63'd0, mm_we}, 64'd1);
      chk("wr_mm_addr", {54'd0, mm_addr}, 64'h3FF);
      chk("wr_mm_wdata", {32'd0, mm_wdata}, 64'hDEADBEEF);
      ack_after(1, 32'hCAFEF00D);
      handshake();

      // no ack at all: timeout
      issue(1'b0, 10'h12, 32'h0, 1'b1, 32'h0, 1'b1);
`ifdef MM_RETRY_EN
      for (int w = 0; w < 3; w++) begin
         count_req(n);
         chk("tmo_window_len", 64'(n), 64'(TO));
         if (w < 2) begin
            chk("backoff_mm_req", {63'd0, mm_req}, 64'd0);
            chk("backoff_no_resp", {63'd0, cc_resp_valid}, 64'd0);
            mm_ack   = 1'b1;
            mm_rdata = 32'h1111_2222;
            tick();
            mm_ack   = 1'b0;
            mm_rdata = '0;
         end
      end
`else
      count_req(n);
      chk("tmo_window_len", 64'(n), 64'(TO));
`endif
      chk("tmo_resp_valid", {63'd0, cc_resp_valid}, 64'd1);
      handshake();

      // ack lands on the cycle the timeout count is reached
      issue(1'b0, 10'h21, 32'h0, 1'b1, 32'hA5A5_0021, 1'b0);
      ack_after(TO, 32'hA5A5_0021);
      handshake();

      // response backpressure with a spurious ack during RESP
      issue(1'b0, 10'h33, 32'h0, 1'b1, 32'h1234_5678, 1'b0);
      ack_after(2, 32'h1234_5678);
      for (int i = 0; i < 4; i++) begin
         chk("bp_resp_valid", {63'd0, cc_resp_valid}, 64'd1);
         chk("bp_resp_rdata", {32'd0, cc_resp_rdata}, 64'h1234_5678);
         chk("bp_resp_err", {63'd0, cc_resp_err}, 64'd0);
         chk("bp_req_ready", {63'd0, cc_req_ready}, 64'd0);
         chk("bp_mm_req", {63'd0, mm_req}, 64'd0);
         if (i == 1) begin
            mm_ack   = 1'b1;
            mm_rdata = 32'hFFFF_FFFF;
         end
         tick();
         mm_ack   = 1'b0;
         mm_rdata = '0;
      end
      handshake();

      // reset two cycles into WAIT abandons the read silently
      issue(1'b0, 10'd9, 32'h0, 1'b0, 32'h0, 1'b0);
      tick();
      tick();
      chk("pre_reset_mm_req", {63'd0, mm_req}, 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("post_reset_mm_req", {63'd0, mm_req}, 64'd0);
      chk("post_reset_req_ready", {63'd0, cc_req_ready}, 64'd1);
      chk("post_reset_resp_valid", {63'd0, cc_resp_valid}, 64'd0);
      repeat (3) tick();
      chk("post_reset_no_resp", {63'd0, cc_resp_valid}, 64'd0);

      issue(1'b0, 10'd7, 32'h0, 1'b1, 32'h7, 1'b0);
      ack_after(2, 32'h7);
      handshake();

      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
